hash_work_controller: RTL and testbench
=======================================

Name: hash_work_controller

Overview:
- Sequences one double-SHA256 hasher pipeline for one unit of work (256-bit midstate, 96-bit data, nonce range).
- Issues nonces to the pipeline and skips results during the pipeline fill.
- Attributes each pipeline output to the nonce that produced it, detects golden tickets, and queues them in a small FIFO for the comm block.
- Sits between jtag_comm and the sha256_pipe130/pipe123 pair, replacing ad-hoc counter logic in the top level.

Parameters:
- PIPE_LATENCY, 254: cycles from hasher_nonce being driven to the matching hash_word arriving; must be ≥1.
- GOLDEN_TARGET, 32'hA41F32E7: hash_word value that marks a golden ticket.
- FIFO_DEPTH, 4: golden nonce FIFO entries; power of two, ≥2.

Ports:
- hash_clk  in  1  — hashing clock.
- reset_n  in  1  — asynchronous, active-low reset.
- work_valid  in  1  — one-cycle strobe; new work is present on the work_* inputs.
- work_midstate  in  256  — midstate for new work.
- work_data  in  96  — trailing header data for new work.
- work_nonce_start  in  32  — first nonce of the range.
- work_nonce_end  in  32  — last nonce of the range (inclusive).
- hasher_midstate  out  256  — registered midstate to the pipeline.
- hasher_data  out  96  — registered data to the pipeline.
- hasher_nonce  out  32  — registered nonce to the pipeline.
- hash_word  in  32  — final hash word from the pipeline.
- golden_valid  out  1  — FIFO head valid.
- golden_nonce  out  32  — FIFO head nonce.
- golden_ready  in  1  — consumer pops the head when golden_valid && golden_ready.
- busy  out  1  — state is FILL or RUN.
- exhausted  out  1  — state is DONE.
- dropped_count  out  8  — saturating count of golden nonces lost to a full FIFO.
- work_pending  out  1  — second work slot occupied; tied 0 unless WORK_QUEUE_EN.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all hasher_* outputs=0; FIFO empty.
  - golden_valid=0, golden_nonce=0, busy=0, exhausted=0, dropped_count=0, work_pending=0.
- Range arithmetic is modulo 2^32. Range length = end−start+1; end==start−1 means the full 2^32 range. Wrap through 0xFFFFFFFF is legal.
- Two internal counters:
  - issue_nonce drives hasher_nonce.
  - check_nonce tracks the nonce whose hash is present on hash_word.
- Both counters advance only by +1 and are compared to end for equality only.
- States:
  - IDLE: outputs hold. work_valid → FILL.
  - FILL: a fill counter counts PIPE_LATENCY cycles; hash_word is ignored. After the last fill cycle → RUN.
  - RUN: each cycle, hash_word is compared against check_nonce, then check_nonce increments. When check_nonce==end is checked → DONE.
  - DONE: exhausted=1; hasher_nonce holds end. work_valid → FILL.
- On accepting work (work_valid sampled):
  - Next edge: hasher_midstate/data loaded; hasher_nonce=issue_nonce=start; check_nonce=start; fill counter cleared.
  - The first nonce is on the pipeline input in the cycle after the strobe.
- Issuing:
  - issue_nonce increments each cycle in FILL/RUN until it equals end, then holds.
  - Issuing is independent of FILL/RUN, so a range shorter than PIPE_LATENCY still completes.
- Match:
  - In RUN, hash_word==GOLDEN_TARGET pushes check_nonce into the FIFO at the next edge.
  - golden_valid rises 1 cycle after the matching hash_word is sampled.
  - FIFO is first-word-fall-through.
- FIFO full:
  - A push with no simultaneous pop is dropped and dropped_count increments, saturating at 255.
  - Push and pop in the same cycle while full are both performed; nothing is dropped.
- work_valid while busy (macro off): aborts the current work. Same actions as new work; in-flight results are discarded via FILL. FIFO contents and dropped_count are kept.
- work_valid in the same cycle as the final check: the final check is still performed (a push may occur), then the new work is loaded.

Optional Feature:
- Macro: HASH_WORK_QUEUE_EN.
- With the macro:
  - work_valid while busy stores the work in a pending slot; work_pending=1. A later work_valid overwrites the slot.
  - On the cycle DONE would be entered, the pending work is loaded instead and the state goes directly to FILL. No DONE cycle occurs; work_pending clears.
  - work_valid in IDLE/DONE starts immediately.
- Without the macro: the abort semantics above apply; work_pending=0.

Decomposition:
- Package hash_ctrl_pkg:
  - state enum {IDLE, FILL, RUN, DONE};
  - NONCE_W=32, MIDSTATE_W=256, DATA_W=96;
  - default GOLDEN_TARGET constant.
- Sub-module golden_fifo: synchronous FWFT FIFO, DEPTH/WIDTH parameters, full/empty flags, simultaneous push/pop handling.

Test Plan:
- Reset mid-RUN → all outputs return to reset values immediately; FIFO empty; dropped_count=0.
- Work start=0x100, end=0x1FF, PIPE_LATENCY=254; hash_word=GOLDEN_TARGET exactly 254+0x20 cycles after the first nonce → golden_nonce=0x120 one cycle later; exhausted after 254+256 cycles.
- start=0xFFFFFFFE, end=0x00000001 → hasher_nonce sequence FFFFFFFE, FFFFFFFF, 0, 1 then holds; 4 checks, then DONE.
- Six consecutive matches, golden_ready=0, FIFO_DEPTH=4 → 4 entries queued, dropped_count=2; then pop all → nonces in order.
- work_valid mid-RUN (macro off) with GOLDEN_TARGET held on hash_word → no push for PIPE_LATENCY cycles after the abort; new range checked from its start.
- HASH_WORK_QUEUE_EN: second work during RUN → work_pending=1; on completion the second work loads with no DONE cycle; exhausted stays 0.

Source files
------------

// File: rtl/hash_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hash_ctrl_pkg
// Shared widths, the default golden-ticket word and the controller state type
// for hash_work_controller and its golden nonce FIFO.
// -----------------------------------------------------------------------------
package hash_ctrl_pkg;

    localparam int NONCE_W    = 32;
    localparam int MIDSTATE_W = 256;
    localparam int DATA_W     = 96;

    // Final hash word that marks a golden ticket.
    localparam logic [NONCE_W-1:0] DEFAULT_GOLDEN_TARGET = 32'hA41F32E7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/golden_fifo.sv
// -----------------------------------------------------------------------------
// golden_fifo
// Small first-word-fall-through FIFO holding golden nonces for the comm block.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_data   write request and data
//   i_pop            read request (ignored while empty)
//   o_valid, o_data  head entry (o_data reads 0 while empty)
//   o_full, o_empty  occupancy flags
//
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is discarded and the caller accounts for the loss.
// -----------------------------------------------------------------------------
module golden_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_valid = !o_empty;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/hash_work_controller.sv
// -----------------------------------------------------------------------------
// hash_work_controller
// Sequences one double-SHA256 pipeline over a nonce range: loads the work,
// issues nonces, skips hash words during the pipeline fill, attributes each
// later hash word to its nonce and queues golden tickets in a FIFO.
//
// Ports:
//   hash_clk, reset_n                  clock, asynchronous active-low reset
//   work_valid, work_*                 new work strobe and contents
//   hasher_midstate/data/nonce         registered pipeline inputs
//   hash_word                          final hash word from the pipeline
//   golden_valid/nonce, golden_ready   FWFT golden nonce output
//   busy, exhausted                    FILL/RUN, DONE status
//   dropped_count                      saturating count of lost golden nonces
//   work_pending                       second work slot occupied
//
// Build option: HASH_WORK_QUEUE_EN - work arriving while busy waits in a
// pending slot and starts when the current range finishes, instead of
// aborting the current range.
// -----------------------------------------------------------------------------
module hash_work_controller
    import hash_ctrl_pkg::*;
#(
    parameter int                 PIPE_LATENCY  = 254,
    parameter logic [NONCE_W-1:0] GOLDEN_TARGET = DEFAULT_GOLDEN_TARGET,
    parameter int                 FIFO_DEPTH    = 4
) (
    input  logic                  hash_clk,
    input  logic                  reset_n,
    input  logic                  work_valid,
    input  logic [MIDSTATE_W-1:0] work_midstate,
    input  logic [DATA_W-1:0]     work_data,
    input  logic [NONCE_W-1:0]    work_nonce_start,
    input  logic [NONCE_W-1:0]    work_nonce_end,
    output logic [MIDSTATE_W-1:0] hasher_midstate,
    output logic [DATA_W-1:0]     hasher_data,
    output logic [NONCE_W-1:0]    hasher_nonce,
    input  logic [NONCE_W-1:0]    hash_word,
    output logic                  golden_valid,
    output logic [NONCE_W-1:0]    golden_nonce,
    input  logic                  golden_ready,
    output logic                  busy,
    output logic                  exhausted,
    output logic [7:0]            dropped_count,
    output logic                  work_pending
);

    localparam int FILL_W = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

    ctrl_state_t            r_state;
    ctrl_state_t            w_state_next;
    logic [MIDSTATE_W-1:0]  r_midstate;
    logic [DATA_W-1:0]      r_data;
    logic [NONCE_W-1:0]     r_issue_nonce;
    logic [NONCE_W-1:0]     r_check_nonce;
    logic [NONCE_W-1:0]     r_end_nonce;
    logic [FILL_W-1:0]      r_fill_cnt;
    logic [7:0]             r_dropped;

    logic                   w_busy;
    logic                   w_fill_last;
    logic                   w_check_last;
    logic                   w_load;
    logic                   w_accept;
    logic                   w_load_pend;
    logic [MIDSTATE_W-1:0]  w_ld_midstate;
    logic [DATA_W-1:0]      w_ld_data;
    logic [NONCE_W-1:0]     w_ld_start;
    logic [NONCE_W-1:0]     w_ld_end;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;

    assign w_busy       = (r_state == FILL) || (r_state == RUN);
    assign w_fill_last  = (r_state == FILL) &&
                          (r_fill_cnt == FILL_W'(PIPE_LATENCY - 1));
    // The nonce equal to end is the last one whose hash is checked.
    assign w_check_last = (r_state == RUN) && (r_check_nonce == r_end_nonce);

`ifdef HASH_WORK_QUEUE_EN
    logic                   r_pend_valid;
    logic [MIDSTATE_W-1:0]  r_pend_midstate;
    logic [DATA_W-1:0]      r_pend_data;
    logic [NONCE_W-1:0]     r_pend_start;
    logic [NONCE_W-1:0]     r_pend_end;
    logic                   w_store;

    // A finishing range hands over to the pending work; with the slot empty,
    // work arriving on the final check starts directly rather than parking.
    assign w_load_pend = w_check_last && r_pend_valid;
    assign w_accept    = work_valid && (!w_busy || (w_check_last && !r_pend_valid));
    assign w_store     = work_valid && w_busy && !w_accept;

    assign w_ld_midstate = w_load_pend ? r_pend_midstate : work_midstate;
    assign w_ld_data     = w_load_pend ? r_pend_data     : work_data;
    assign w_ld_start    = w_load_pend ? r_pend_start    : work_nonce_start;
    assign w_ld_end      = w_load_pend ? r_pend_end      : work_nonce_end;

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_valid    <= 1'b0;
            r_pend_midstate <= '0;
            r_pend_data     <= '0;
            r_pend_start    <= '0;
            r_pend_end      <= '0;
        end else begin
            if (w_store) begin
                r_pend_valid    <= 1'b1;
                r_pend_midstate <= work_midstate;
                r_pend_data     <= work_data;
                r_pend_start    <= work_nonce_start;
                r_pend_end      <= work_nonce_end;
            end else if (w_load_pend) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign work_pending = r_pend_valid;
`else
    // New work always restarts the controller; results still in flight for
    // the old range drain out during the new FILL.
    assign w_load_pend   = 1'b0;
    assign w_accept      = work_valid;
    assign w_ld_midstate = work_midstate;
    assign w_ld_data     = work_data;
    assign w_ld_start    = work_nonce_start;
    assign w_ld_end      = work_nonce_end;
    assign work_pending  = 1'b0;
`endif

    assign w_load = w_accept || w_load_pend;

    // ---------------- state machine ----------------
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: w_state_next = IDLE;
            FILL: if (w_fill_last)  w_state_next = RUN;
            RUN:  if (w_check_last) w_state_next = DONE;
            DONE: w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
        if (w_load) begin
            w_state_next = FILL;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_midstate    <= '0;
            r_data        <= '0;
            r_issue_nonce <= '0;
            r_check_nonce <= '0;
            r_end_nonce   <= '0;
            r_fill_cnt    <= '0;
        end else if (w_load) begin
            r_midstate    <= w_ld_midstate;
            r_data        <= w_ld_data;
            r_issue_nonce <= w_ld_start;
            r_check_nonce <= w_ld_start;
            r_end_nonce   <= w_ld_end;
            r_fill_cnt    <= '0;
        end else begin
            // Issuing runs through FILL too, so short ranges finish issuing
            // before the first result even appears.
            if (w_busy && (r_issue_nonce != r_end_nonce)) begin
                r_issue_nonce <= r_issue_nonce + NONCE_W'(1);
            end
            if (r_state == FILL) begin
                r_fill_cnt <= r_fill_cnt + FILL_W'(1);
            end
            if ((r_state == RUN) && !w_check_last) begin
                r_check_nonce <= r_check_nonce + NONCE_W'(1);
            end
        end
    end

    assign hasher_midstate = r_midstate;
    assign hasher_data     = r_data;
    assign hasher_nonce    = r_issue_nonce;
    assign busy            = w_busy;
    assign exhausted       = (r_state == DONE);

    // ---------------- golden tickets ----------------
    assign w_push = (r_state == RUN) && (hash_word == GOLDEN_TARGET);
    assign w_pop  = golden_ready && golden_valid;

    golden_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NONCE_W)
    ) u_golden_fifo (
        .i_clk   (hash_clk),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_data  (r_check_nonce),
        .i_pop   (w_pop),
        .o_valid (golden_valid),
        .o_data  (golden_nonce),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // A full FIFO still takes a push when the head leaves in the same cycle.
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dropped <= '0;
        end else if (w_push && w_fifo_full && !w_pop && (r_dropped != 8'hFF)) begin
            r_dropped <= r_dropped + 8'd1;
        end
    end

    assign dropped_count = r_dropped;

endmodule

// File: tb/tb_hash_work_controller.sv
module tb_hash_work_controller;
    import hash_ctrl_pkg::*;

    localparam int          L     = 254;
    localparam int          DEPTH = 4;
    localparam logic [31:0] GT    = 32'hA41F32E7;

    logic         hash_clk = 1'b0;
    logic         reset_n  = 1'b0;
    logic         work_valid = 1'b0;
    logic [255:0] work_midstate = '0;
    logic [95:0]  work_data = '0;
    logic [31:0]  work_nonce_start = '0;
    logic [31:0]  work_nonce_end = '0;
    logic [255:0] hasher_midstate;
    logic [95:0]  hasher_data;
    logic [31:0]  hasher_nonce;
    logic [31:0]  hash_word = '0;
    logic         golden_valid;
    logic [31:0]  golden_nonce;
    logic         golden_ready = 1'b0;
    logic         busy;
    logic         exhausted;
    logic [7:0]   dropped_count;
    logic         work_pending;

    always #5 hash_clk = ~hash_clk;

    hash_work_controller #(
        .PIPE_LATENCY  (L),
        .GOLDEN_TARGET (GT),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .hash_clk         (hash_clk),
        .reset_n          (reset_n),
        .work_valid       (work_valid),
        .work_midstate    (work_midstate),
        .work_data        (work_data),
        .work_nonce_start (work_nonce_start),
        .work_nonce_end   (work_nonce_end),
        .hasher_midstate  (hasher_midstate),
        .hasher_data      (hasher_data),
        .hasher_nonce     (hasher_nonce),
        .hash_word        (hash_word),
        .golden_valid     (golden_valid),
        .golden_nonce     (golden_nonce),
        .golden_ready     (golden_ready),
        .busy             (busy),
        .exhausted        (exhausted),
        .dropped_count    (dropped_count),
        .work_pending     (work_pending)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // A work item is a start nonce and a length n. Counting the cycle after the
    // strobe as k=1, the pipeline input carries start+min(k-1,n-1); the hash
    // sampled in cycle k belongs to nonce start+(k-L-1) for L+1 <= k <= L+n.
    logic         m_active;
    logic [31:0]  m_s;
    longint       m_n, m_k;
    logic [255:0] m_mid;
    logic [95:0]  m_dat;
    logic [31:0]  q[$];
    int           m_drop;
    logic         m_pend;
    logic [31:0]  p_s, p_e;
    logic [255:0] p_mid;
    logic [95:0]  p_dat;

    function automatic logic m_busy();
        return m_active && (m_k <= longint'(L) + m_n);
    endfunction
    function automatic logic m_run();
        return m_active && (m_k >= longint'(L) + 1) && (m_k <= longint'(L) + m_n);
    endfunction
    function automatic logic [31:0] m_nonce();
        longint off;
        if (!m_active) return 32'd0;
        off = (m_k - 1 < m_n - 1) ? m_k - 1 : m_n - 1;
        return m_s + 32'(off);
    endfunction

    task automatic m_start(input logic [31:0] s, input logic [31:0] e,
                           input logic [255:0] mid, input logic [95:0] dat);
        logic [31:0] diff;
        diff = e - s;
        m_active = 1'b1;
        m_s = s;
        m_n = longint'(diff) + 1;
        m_k = 1;
        m_mid = mid;
        m_dat = dat;
    endtask

    task automatic m_reset();
        m_active = 1'b0; m_s = '0; m_n = 1; m_k = 0; m_mid = '0; m_dat = '0;
        q.delete(); m_drop = 0; m_pend = 1'b0;
    endtask

    function automatic logic [31:0] rnd_hash();
        logic [31:0] h;
        h = $urandom();
        if (h == GT) h = ~h;
        return h;
    endfunction
    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction
    function automatic logic [95:0] rnd96();
        logic [95:0] v;
        for (int i = 0; i < 3; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Drive inputs for the coming edge and advance the model across it.
    task automatic apply(input logic wv, input logic [31:0] s, input logic [31:0] e,
                         input logic [31:0] hw, input logic rdy);
        logic run, pop, push, last, bz;
        logic [255:0] mid;
        logic [95:0]  dat;
        mid = rnd256();
        dat = rnd96();
        work_valid = wv; work_nonce_start = s; work_nonce_end = e;
        work_midstate = mid; work_data = dat;
        hash_word = hw; golden_ready = rdy;
        run  = m_run();
        bz   = m_busy();
        pop  = rdy && (q.size() > 0);
        push = run && (hw == GT);
        if (push && (q.size() == DEPTH) && !pop) begin
            if (m_drop < 255) m_drop++;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(m_s + 32'(m_k - L - 1));
        end
        last = run && (m_k == longint'(L) + m_n);
`ifdef HASH_WORK_QUEUE_EN
        if (last && m_pend) begin
            m_start(p_s, p_e, p_mid, p_dat);
            m_pend = wv;
            if (wv) begin p_s = s; p_e = e; p_mid = mid; p_dat = dat; end
        end else if (wv && (!bz || last)) begin
            m_start(s, e, mid, dat);
        end else begin
            if (wv) begin m_pend = 1'b1; p_s = s; p_e = e; p_mid = mid; p_dat = dat; end
            if (m_active) m_k++;
        end
`else
        if (wv) m_start(s, e, mid, dat);
        else if (m_active) m_k++;
`endif
    endtask

    task automatic idle(input logic [31:0] hw, input logic rdy);
        apply(1'b0, 32'd0, 32'd0, hw, rdy);
    endtask

    task automatic tick(input string tag);
        @(posedge hash_clk);
        #1;
        chk({tag, " busy"}, busy, m_busy());
        chk({tag, " exhausted"}, exhausted, m_active && !m_busy());
        chk({tag, " hasher_nonce"}, hasher_nonce, m_nonce());
        chk({tag, " hasher_midstate"}, hasher_midstate, m_mid);
        chk({tag, " hasher_data"}, hasher_data, m_dat);
        chk({tag, " golden_valid"}, golden_valid, q.size() > 0);
        if (q.size() > 0) chk({tag, " golden_nonce"}, golden_nonce, q[0]);
        chk({tag, " dropped_count"}, dropped_count, 8'(m_drop));
        chk({tag, " work_pending"}, work_pending, m_pend);
    endtask

    task automatic do_reset(input string tag);
        #2 reset_n = 1'b0;
        m_reset();
        #1;
        chk({tag, " rst hasher_midstate"}, hasher_midstate, 256'd0);
        chk({tag, " rst hasher_data"}, hasher_data, 96'd0);
        chk({tag, " rst hasher_nonce"}, hasher_nonce, 32'd0);
        chk({tag, " rst golden_valid"}, golden_valid, 1'b0);
        chk({tag, " rst golden_nonce"}, golden_nonce, 32'd0);
        chk({tag, " rst busy"}, busy, 1'b0);
        chk({tag, " rst exhausted"}, exhausted, 1'b0);
        chk({tag, " rst dropped_count"}, dropped_count, 8'd0);
        chk({tag, " rst work_pending"}, work_pending, 1'b0);
        @(posedge hash_clk);
        @(posedge hash_clk);
        #3 reset_n = 1'b1;
        $display("reset %s applied", tag);
    endtask

    typedef struct {
        logic [31:0] s;
        logic [31:0] e;
        int          idx;   // RUN index carrying the golden word
        longint      len;   // expected range length
        logic [31:0] gold;  // expected golden nonce
    } vec_t;

    initial begin
        vec_t vt[5];
        int cnt;
        vt[0] = '{32'h0000_0100, 32'h0000_01FF, 32, 256, 32'h0000_0120};
        vt[1] = '{32'hFFFF_FFFE, 32'h0000_0001,  3,   4, 32'h0000_0001};
        vt[2] = '{32'h0000_0005, 32'h0000_0005,  0,   1, 32'h0000_0005};
        vt[3] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 15,  16, 32'hFFFF_FFFF};
        vt[4] = '{32'h0000_0007, 32'h0000_0010,  9,  10, 32'h0000_0010};

        m_reset();
        do_reset("initial");
        idle(rnd_hash(), 1'b0);
        tick("idle");

        // ---- table-driven ranges ----
        for (int v = 0; v < 5; v++) begin
            apply(1'b1, vt[v].s, vt[v].e, rnd_hash(), 1'b0);
            tick("vec start");
            for (longint c = 1; c <= longint'(L) + vt[v].len; c++) begin
                idle((c == longint'(L) + 1 + vt[v].idx) ? GT : rnd_hash(), 1'b0);
                tick("vec run");
            end
            chk("vec exhausted", exhausted, 1'b1);
            chk("vec nonce holds end", hasher_nonce, vt[v].e);
            chk("vec golden_valid", golden_valid, 1'b1);
            chk("vec golden_nonce", golden_nonce, vt[v].gold);
            idle(rnd_hash(), 1'b1);
            tick("vec pop");
            chk("vec fifo empty", golden_valid, 1'b0);
            $display("vector %0d: start=%08h end=%08h golden=%08h", v, vt[v].s, vt[v].e, golden_nonce);
        end

        // ---- six matches into a 4-entry FIFO ----
        apply(1'b1, 32'h40, 32'h4F, rnd_hash(), 1'b0);
        tick("six start");
        for (int c = 1; c <= L + 16; c++) begin
            idle((c >= L + 1 && c <= L + 6) ? GT : rnd_hash(), 1'b0);
            tick("six run");
        end
        chk("six dropped_count", dropped_count, 8'd2);
        for (int i = 0; i < 4; i++) begin
            chk("six pop valid", golden_valid, 1'b1);
            chk("six pop nonce", golden_nonce, 32'h40 + 32'(i));
            idle(rnd_hash(), 1'b1);
            tick("six pop");
        end
        chk("six drained", golden_valid, 1'b0);
        $display("six matches: dropped=%0d", dropped_count);

`ifndef HASH_WORK_QUEUE_EN
        // ---- abort mid-RUN with the golden word held ----
        apply(1'b1, 32'h1000, 32'h10FF, rnd_hash(), 1'b1);
        tick("abort start");
        for (int c = 1; c < L + 20; c++) begin
            idle((c > L + 10) ? GT : rnd_hash(), 1'b1);
            tick("abort old");
        end
        apply(1'b1, 32'h2000, 32'h20FF, GT, 1'b1);
        tick("abort strobe");
        cnt = 0;
        for (int c = 1; c <= L + 1; c++) begin
            if (c >= 2 && golden_valid) cnt++;
            idle(GT, 1'b1);
            tick("abort fill");
        end
        chk("abort no push during fill", 32'(cnt), 32'd0);
        chk("abort first valid", golden_valid, 1'b1);
        chk("abort first nonce", golden_nonce, 32'h2000);
        for (int c = L + 2; c <= L + 257; c++) begin
            idle(GT, 1'b1);
            tick("abort new");
        end
        chk("abort exhausted", exhausted, 1'b1);
        idle(rnd_hash(), 1'b1);
        tick("abort drain");
        $display("abort: pushes during fill=%0d", cnt);
`else
        // ---- queued second work ----
        apply(1'b1, 32'h300, 32'h30F, rnd_hash(), 1'b1);
        tick("queue A");
        cnt = 0;
        for (int c = 1; c <= L + 16; c++) begin
            if (c == L + 3) apply(1'b1, 32'h400, 32'h407, rnd_hash(), 1'b1);
            else idle(rnd_hash(), 1'b1);
            tick("queue run");
            if (c == L + 3) chk("queue pending set", work_pending, 1'b1);
            if (exhausted) cnt++;
        end
        chk("queue B loaded", hasher_nonce, 32'h400);
        chk("queue busy", busy, 1'b1);
        chk("queue pending clear", work_pending, 1'b0);
        chk("queue no DONE cycle", 32'(cnt), 32'd0);
        for (int c = 1; c <= L + 8; c++) begin
            idle(rnd_hash(), 1'b1);
            tick("queue B");
        end
        chk("queue B exhausted", exhausted, 1'b1);
        $display("queue: B loaded, DONE cycles before B=%0d", cnt);
`endif

        // ---- randomized work against the model ----
        for (int w = 0; w < 8; w++) begin
            logic [31:0] s, e;
            int len, cyc;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 300) : $urandom_range(1, 40);
            s = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom();
            e = s + 32'(len - 1);
            apply(1'b1, s, e, rnd_hash(), 1'($urandom_range(0, 1)));
            tick("rand start");
            cyc = L + len + $urandom_range(0, 5);
            for (int c = 1; c <= cyc; c++) begin
                logic [31:0] hw;
                hw = ($urandom_range(0, 5) == 0) ? GT : rnd_hash();
                if ($urandom_range(0, 299) == 0) begin
                    logic [31:0] s2;
                    s2 = $urandom();
                    apply(1'b1, s2, s2 + 32'($urandom_range(0, 30)), hw, 1'($urandom_range(0, 1)));
                end else begin
                    idle(hw, 1'($urandom_range(0, 1)));
                end
                tick("rand");
            end
            $display("random work %0d: start=%08h len=%0d dropped=%0d", w, s, len, dropped_count);
        end

        // ---- reset while running with a non-empty FIFO ----
        apply(1'b1, 32'h500, 32'h5FF, rnd_hash(), 1'b0);
        tick("rst start");
        for (int c = 1; c <= L + 8; c++) begin
            idle((c > L) ? GT : rnd_hash(), 1'b0);
            tick("rst run");
        end
        chk("rst precondition fifo", golden_valid, 1'b1);
        do_reset("mid-run");
        idle(rnd_hash(), 1'b1);
        tick("post reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
